// File: rtl/morra_match_ctrl.sv
// Morra match sequencer: starts and configures the game core, collects one move per player
// per round, feeds the pair to the core for CORE_LAT cycles, then samples and scores the verdict.
module morra_match_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CORE_LAT       = 2,
    parameter int MAX_ROUNDS     = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       match_req,
    input  logic [3:0] match_cfg,
    output logic       match_busy,
    input  logic [1:0] p1_move,
    input  logic       p1_valid,
    output logic       p1_ready,
    input  logic [1:0] p2_move,
    input  logic       p2_valid,
    output logic       p2_ready,
    output logic       core_start,
    output logic [1:0] core_p1,
    output logic [1:0] core_p2,
    input  logic [1:0] core_round,
    input  logic [1:0] core_game,
    output logic       round_valid,
    output logic [1:0] round_result,
    output logic [4:0] p1_wins,
    output logic [4:0] p2_wins,
    output logic [4:0] rounds_played,
    output logic [1:0] timeout_flags,
    output logic       match_done,
    output logic [1:0] match_result,
    output logic [2:0] dbg_state
);
    // Move handshake: a move transfers on a cycle where pX_valid && pX_ready are both high.
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAT_LAST = 3'(CORE_LAT - 1);
    localparam logic [4:0]    MAX_R    = 5'(MAX_ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_CONFIG  = 3'd2,
        S_COLLECT = 3'd3,
        S_APPLY   = 3'd4,
        S_RESULT  = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cfg_q, cfg_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    lat_q, lat_d;
    logic [1:0]    m1_q, m1_d, m2_q, m2_d;
    logic          have1_q, have1_d, have2_q, have2_d;
    logic [1:0]    tflags_q, tflags_d;
    logic          rv_q, rv_d;
    logic [1:0]    rres_q, rres_d;
    logic [4:0]    p1w_q, p1w_d, p2w_q, p2w_d, rp_q, rp_d;
    logic [1:0]    mres_q, mres_d;

    logic       cap1, cap2, both, expire;
    logic [4:0] rp_inc;

    assign cap1   = p1_valid && p1_ready;
    assign cap2   = p2_valid && p2_ready;
    assign both   = (have1_q || cap1) && (have2_q || cap2);
    assign expire = (state_q == S_COLLECT) && (timer_q == TO_LAST);
    assign rp_inc = (rp_q == 5'd31) ? rp_q : rp_q + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cfg_q    <= '0;
            timer_q  <= '0;
            lat_q    <= '0;
            m1_q     <= '0;
            m2_q     <= '0;
            have1_q  <= 1'b0;
            have2_q  <= 1'b0;
            tflags_q <= '0;
            rv_q     <= 1'b0;
            rres_q   <= '0;
            p1w_q    <= '0;
            p2w_q    <= '0;
            rp_q     <= '0;
            mres_q   <= '0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            timer_q  <= timer_d;
            lat_q    <= lat_d;
            m1_q     <= m1_d;
            m2_q     <= m2_d;
            have1_q  <= have1_d;
            have2_q  <= have2_d;
            tflags_q <= tflags_d;
            rv_q     <= rv_d;
            rres_q   <= rres_d;
            p1w_q    <= p1w_d;
            p2w_q    <= p2w_d;
            rp_q     <= rp_d;
            mres_q   <= mres_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (match_req) state_d = S_INIT;
            S_INIT:    state_d = S_CONFIG;
            S_CONFIG:  state_d = S_COLLECT;
            S_COLLECT: if (both || expire) state_d = S_APPLY;
            S_APPLY:   if (lat_q == LAT_LAST) state_d = S_RESULT;
            S_RESULT: begin
                if (core_game != 2'b00 || rp_inc == MAX_R) state_d = S_DONE;
                else                                       state_d = S_COLLECT;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_d    = cfg_q;
        timer_d  = timer_q;
        lat_d    = lat_q;
        m1_d     = m1_q;
        m2_d     = m2_q;
        have1_d  = have1_q;
        have2_d  = have2_q;
        tflags_d = tflags_q;
        rv_d     = 1'b0;
        rres_d   = rres_q;
        p1w_d    = p1w_q;
        p2w_d    = p2w_q;
        rp_d     = rp_q;
        mres_d   = mres_q;

        if (state_q == S_IDLE && match_req) begin
            cfg_d    = match_cfg;
            p1w_d    = '0;
            p2w_d    = '0;
            rp_d     = '0;
            tflags_d = '0;
        end

        if (state_q != S_COLLECT && state_d == S_COLLECT) begin
            timer_d  = '0;
            have1_d  = 1'b0;
            have2_d  = 1'b0;
            tflags_d = '0;
        end

        if (state_q == S_COLLECT) begin
            timer_d = timer_q + 1'b1;
            if (cap1) begin
                m1_d    = p1_move;
                have1_d = 1'b1;
            end
            if (cap2) begin
                m2_d    = p2_move;
                have2_d = 1'b1;
            end
            // A player still missing at expiry is substituted with a null move.
            if (expire && !have1_q && !cap1) begin
                m1_d        = 2'b00;
                have1_d     = 1'b1;
                tflags_d[0] = 1'b1;
            end
            if (expire && !have2_q && !cap2) begin
                m2_d        = 2'b00;
                have2_d     = 1'b1;
                tflags_d[1] = 1'b1;
            end
        end

        if (state_q == S_APPLY) lat_d = lat_q + 3'd1;
        else                    lat_d = '0;

        if (state_q == S_RESULT) begin
            rv_d   = 1'b1;
            rres_d = core_round;
            rp_d   = rp_inc;
            if (core_round == 2'b01) p1w_d = p1w_q + 5'd1;
            if (core_round == 2'b10) p2w_d = p2w_q + 5'd1;
            if (core_game != 2'b00)  mres_d = core_game;
            else if (rp_inc == MAX_R) mres_d = 2'b00;
        end
    end

    always_comb begin
        match_busy = (state_q != S_IDLE);
        core_start = (state_q == S_INIT);
        match_done = (state_q == S_DONE);
        p1_ready   = (state_q == S_COLLECT) && !have1_q;
        p2_ready   = (state_q == S_COLLECT) && !have2_q;
        core_p1    = 2'b00;
        core_p2    = 2'b00;
        case (state_q)
            S_CONFIG: {core_p1, core_p2} = cfg_q;
            S_APPLY: begin
                core_p1 = m1_q;
                core_p2 = m2_q;
            end
            default: ;
        endcase
    end

    assign round_valid   = rv_q;
    assign round_result  = rres_q;
    assign p1_wins       = p1w_q;
    assign p2_wins       = p2w_q;
    assign rounds_played = rp_q;
    assign timeout_flags = tflags_q;
    assign match_result  = mres_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_morra_match_ctrl.sv
// Bench for morra_match_ctrl: table of rounds with hand-computed results, plus
// hand-written sequences for the round cap, reset during APPLY and ignored requests.
module tb_morra_match_ctrl;
    localparam int CORE_LAT = 2;
    localparam logic [2:0] S_IDLE = 3'd0, S_COLLECT = 3'd3, S_APPLY = 3'd4, S_RESULT = 3'd5;

    logic       clk, rst_n, match_req, match_busy;
    logic [3:0] match_cfg;
    logic [1:0] p1_move, p2_move, core_p1, core_p2, core_round, core_game;
    logic       p1_valid, p1_ready, p2_valid, p2_ready, core_start;
    logic       round_valid, match_done;
    logic [1:0] round_result, timeout_flags, match_result;
    logic [4:0] p1_wins, p2_wins, rounds_played;
    logic [2:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] m1;
        logic [1:0] m2;
        int         d1;
        int         d2;
        logic [1:0] rnd;
        logic [1:0] gm;
        int         exp_len;
        logic [1:0] exp_flags;
        int         exp_p1w;
        int         exp_p2w;
        int         exp_rp;
        bit         exp_done;
        logic [1:0] exp_res;
    } vec_t;

    vec_t vecs[6];

    morra_match_ctrl #(.TIMEOUT_CYCLES(255), .CORE_LAT(CORE_LAT), .MAX_ROUNDS(19)) dut (
        .clk(clk), .rst_n(rst_n), .match_req(match_req), .match_cfg(match_cfg),
        .match_busy(match_busy),
        .p1_move(p1_move), .p1_valid(p1_valid), .p1_ready(p1_ready),
        .p2_move(p2_move), .p2_valid(p2_valid), .p2_ready(p2_ready),
        .core_start(core_start), .core_p1(core_p1), .core_p2(core_p2),
        .core_round(core_round), .core_game(core_game),
        .round_valid(round_valid), .round_result(round_result),
        .p1_wins(p1_wins), .p2_wins(p2_wins), .rounds_played(rounds_played),
        .timeout_flags(timeout_flags), .match_done(match_done),
        .match_result(match_result), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE, returns at the negedge of the first COLLECT cycle.
    task automatic start_match(input logic [3:0] cfg, input logic [1:0] prev_res);
        match_req = 1'b1;
        match_cfg = cfg;
        @(posedge clk); @(negedge clk);
        match_req = 1'b0;
        match_cfg = 4'h0;
        chk("init_core_start", core_start, 1'b1);
        chk("init_busy", match_busy, 1'b1);
        chk("init_counters", {p1_wins, p2_wins, rounds_played}, 15'd0);
        chk("init_flags", timeout_flags, 2'b00);
        chk("init_result_kept", match_result, prev_res);
        @(posedge clk); @(negedge clk);
        chk("config_core_start", core_start, 1'b0);
        chk("config_core_p1", core_p1, cfg[3:2]);
        chk("config_core_p2", core_p2, cfg[1:0]);
        @(posedge clk); @(negedge clk);
    endtask

    // Starts at the negedge of the first COLLECT cycle; returns one cycle after RESULT.
    task automatic do_round(input vec_t v);
        int t;
        int napply;
        bit c1, c2;
        logic [1:0] e1, e2;
        core_round = v.rnd;
        core_game  = v.gm;
        p1_move = v.m1;
        p2_move = v.m2;
        c1 = 1'b0;
        c2 = 1'b0;
        t  = 0;
        chk("collect_core_idle", {core_p1, core_p2, core_start}, 5'd0);
        chk("collect_flags_clear", timeout_flags, 2'b00);
        while (dbg_state == S_COLLECT && t < 400) begin
            chk("p1_ready", p1_ready, !c1);
            chk("p2_ready", p2_ready, !c2);
            p1_valid = (v.d1 >= 0) && (t >= v.d1) && !c1;
            p2_valid = (v.d2 >= 0) && (t >= v.d2) && !c2;
            if (p1_valid) c1 = 1'b1;
            if (p2_valid) c2 = 1'b1;
            @(posedge clk); @(negedge clk);
            t++;
        end
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        chk("collect_len", t, v.exp_len);
        e1 = (v.d1 < 0) ? 2'b00 : v.m1;
        e2 = (v.d2 < 0) ? 2'b00 : v.m2;
        napply = 0;
        while (dbg_state == S_APPLY && napply < 20) begin
            chk("apply_core_p1", core_p1, e1);
            chk("apply_core_p2", core_p2, e2);
            chk("apply_flags", timeout_flags, v.exp_flags);
            chk("apply_ready", {p1_ready, p2_ready}, 2'b00);
            @(posedge clk); @(negedge clk);
            napply++;
        end
        chk("apply_len", napply, CORE_LAT);
        chk("result_state", dbg_state, S_RESULT);
        chk("result_core_idle", {core_p1, core_p2}, 4'd0);
        @(posedge clk); @(negedge clk);
        chk("round_valid", round_valid, 1'b1);
        chk("round_result", round_result, v.rnd);
        chk("p1_wins", p1_wins, v.exp_p1w);
        chk("p2_wins", p2_wins, v.exp_p2w);
        chk("rounds_played", rounds_played, v.exp_rp);
        chk("match_done", match_done, v.exp_done);
        if (v.exp_done) chk("match_result", match_result, v.exp_res);
    endtask

    // Called at the DONE negedge; checks the return to IDLE.
    task automatic finish_match(input logic [1:0] res);
        @(posedge clk); @(negedge clk);
        chk("idle_done_pulse", match_done, 1'b0);
        chk("idle_busy", match_busy, 1'b0);
        chk("idle_round_valid", round_valid, 1'b0);
        chk("idle_result_kept", match_result, res);
        core_game = 2'b00;
    endtask

    initial begin
        vec_t v;
        int ep1, ep2;
        //          m1     m2     d1  d2  rnd    gm     len flags  p1w p2w rp done res
        vecs[0] = '{2'b01, 2'b11, 0,  0,  2'b01, 2'b00, 1,   2'b00, 1,  0,  1, 0,  2'b00};
        vecs[1] = '{2'b10, 2'b01, 0,  0,  2'b01, 2'b00, 1,   2'b00, 2,  0,  2, 0,  2'b00};
        vecs[2] = '{2'b11, 2'b10, 0,  0,  2'b01, 2'b10, 1,   2'b00, 3,  0,  3, 1,  2'b10};
        vecs[3] = '{2'b01, 2'b00, 0,  5,  2'b10, 2'b00, 6,   2'b00, 0,  1,  1, 0,  2'b00};
        vecs[4] = '{2'b10, 2'b11, 3,  -1, 2'b00, 2'b00, 255, 2'b10, 0,  1,  2, 0,  2'b00};
        vecs[5] = '{2'b01, 2'b11, -1, 7,  2'b11, 2'b01, 255, 2'b01, 0,  1,  3, 1,  2'b01};

        rst_n = 1'b0;
        match_req = 1'b0;
        match_cfg = 4'h0;
        p1_move = 2'b00;
        p2_move = 2'b00;
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        core_round = 2'b00;
        core_game = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {match_busy, core_start, core_p1, core_p2, p1_ready, p2_ready,
                              round_valid, round_result, match_done, match_result}, 16'd0);
        chk("reset_counters", {p1_wins, p2_wins, rounds_played, timeout_flags}, 17'd0);
        rst_n = 1'b1;
        @(negedge clk);
        p1_valid = 1'b1;
        p2_valid = 1'b1;
        chk("idle_ignores_valid", {p1_ready, p2_ready}, 2'b00);
        @(posedge clk); @(negedge clk);
        chk("idle_stays", dbg_state, S_IDLE);
        p1_valid = 1'b0;
        p2_valid = 1'b0;

        // Match A: plain rounds, P1 wins every round, core ends the game after round 3.
        start_match(4'h0, 2'b00);
        for (int i = 0; i < 3; i++) do_round(vecs[i]);
        finish_match(2'b10);

        // Match B: skewed handshake, supplied null move, then timeouts on each side.
        start_match(4'b1001, 2'b10);
        for (int i = 3; i < 6; i++) do_round(vecs[i]);
        finish_match(2'b01);

        // Match C: core never ends the game, cap of 19 rounds aborts with result 00.
        start_match(4'hF, 2'b01);
        ep1 = 0;
        ep2 = 0;
        for (int i = 0; i < 19; i++) begin
            v.m1 = 2'b01;
            v.m2 = 2'b10;
            v.d1 = 0;
            v.d2 = (i % 3);
            v.rnd = 2'(i % 4);
            v.gm = 2'b00;
            v.exp_len = (i % 3) + 1;
            v.exp_flags = 2'b00;
            if (v.rnd == 2'b01) ep1++;
            if (v.rnd == 2'b10) ep2++;
            v.exp_p1w = ep1;
            v.exp_p2w = ep2;
            v.exp_rp = i + 1;
            v.exp_done = (i == 18);
            v.exp_res = 2'b00;
            do_round(v);
        end
        chk("cap_p1_wins", p1_wins, 5'd5);
        chk("cap_p2_wins", p2_wins, 5'd5);
        finish_match(2'b00);

        // Match D: match_req held in COLLECT is ignored, then reset during APPLY.
        start_match(4'h3, 2'b00);
        match_req = 1'b1;
        match_cfg = 4'hA;
        for (int i = 0; i < 3; i++) begin
            chk("req_ignored_state", dbg_state, S_COLLECT);
            chk("req_ignored_start", core_start, 1'b0);
            @(posedge clk); @(negedge clk);
        end
        match_req = 1'b0;
        p1_move = 2'b11;
        p2_move = 2'b01;
        p1_valid = 1'b1;
        p2_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        chk("d_apply_state", dbg_state, S_APPLY);
        chk("d_apply_moves", {core_p1, core_p2}, 4'b1101);
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", {match_busy, core_start, core_p1, core_p2, p1_ready, p2_ready,
                            round_valid, round_result, match_done, match_result}, 16'd0);
        chk("rst_counters", {p1_wins, p2_wins, rounds_played, timeout_flags}, 17'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", match_done, 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_release_idle", {match_busy, match_done, dbg_state}, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/morra_match_ctrl.md
Name: morra_match_ctrl

Overview:
- Sequences one Morra match on the game core: pulses the core start, loads the round-count configuration, then collects one move per player per round over valid/ready handshakes.
- Presents each move pair to the core, samples the round and game verdicts, keeps the score, and reports the match outcome.
- Sits between the two player front-ends and the game core.

Parameters:
- TIMEOUT_CYCLES, 255, cycles COLLECT waits for the missing move(s) before substituting 2'b00.
- CORE_LAT, 2, cycles a move pair is held on core_p1/core_p2 before core_round/core_game are sampled (range 1..7).
- MAX_ROUNDS, 19, hard cap on RESULT visits per match.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- match_req  in  1  start-match request; honoured only in IDLE.
- match_cfg  in  4  extra-rounds configuration, sampled with match_req.
- match_busy  out  1  high in every state except IDLE.
- p1_move  in  2  player-1 move: 01/10/11 valid, 00 null.
- p1_valid  in  1  player-1 move valid.
- p1_ready  out  1  player-1 move accepted.
- p2_move, p2_valid, p2_ready  same as player 1, for player 2.
- core_start  out  1  core START.
- core_p1, core_p2  out  2 each  core P1/P2.
- core_round  in  2  core ROUND: 00 void, 01 P1, 10 P2, 11 draw.
- core_game  in  2  core GAME: 00 in progress, else final result.
- round_valid  out  1  one-cycle pulse per sampled round.
- round_result  out  2  registered core_round, valid with round_valid.
- p1_wins, p2_wins, rounds_played  out  5 each  match counters.
- timeout_flags  out  2  bit0/bit1 = player 1/2 timed out in the last round.
- match_done  out  1  one-cycle pulse at match end.
- match_result  out  2  final core_game; 00 = aborted at MAX_ROUNDS.

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - All outputs 0: core_p1/core_p2 = 00, core_start = 0.
  - Counters, flags, match_result and internal timers = 0.
  - Reset mid-match abandons the match; no match_done.
- IDLE: match_req = 1 -> latch match_cfg, clear counters and timeout_flags -> INIT. match_result keeps its last value until the next match_done.
- INIT (1 cycle): core_start = 1, core_p1/core_p2 = 00 -> CONFIG.
- CONFIG (1 cycle): {core_p1, core_p2} = latched match_cfg -> COLLECT.
- COLLECT:
  - core_p1/core_p2 = 00.
  - pX_ready = 1 while that player's move is not yet captured; capture on pX_valid && pX_ready. Both players may be captured in the same cycle.
  - Timer counts each cycle. When it reaches TIMEOUT_CYCLES-1 with a move missing, the missing move(s) become 00 and the matching timeout_flags bit(s) are set.
  - When both moves are held, go to APPLY. The timer is cleared on entry to COLLECT.
  - ready deasserts the cycle after capture.
- APPLY: drive captured moves on core_p1/core_p2 for exactly CORE_LAT cycles -> RESULT.
- RESULT (1 cycle):
  - Sample core_round and core_game; round_valid = 1; round_result = core_round.
  - rounds_played += 1 (saturating at 31).
  - 01 -> p1_wins += 1; 10 -> p2_wins += 1; 11 and 00 -> no score change.
  - timeout_flags cleared on the next entry to COLLECT.
  - Next state:
    - core_game != 00 -> DONE with match_result = core_game.
    - Otherwise, rounds_played (post-increment) == MAX_ROUNDS -> DONE with match_result = 00.
    - Otherwise -> COLLECT.
- DONE (1 cycle): match_done = 1 -> IDLE.
- match_req outside IDLE is ignored. Player valids outside COLLECT are ignored (ready = 0).
- Moves of 00 supplied by a player are accepted and forwarded unchanged.

Test Plan:
- Basic match: cfg = 0; rounds (01,11),(10,01),(11,10) each with both valids together; core model returns 01 each round and GAME = 10 after round 3 -> three round_valid pulses, p1_wins = 3, match_done with match_result = 10, core_start high exactly one cycle after match_req.
- Skewed handshake: p1_valid 5 cycles before p2_valid -> p1_ready drops after capture, APPLY starts 1 cycle after p2 capture, core_p1/core_p2 held exactly CORE_LAT cycles.
- Timeout: only p1 supplies a move -> after TIMEOUT_CYCLES cycles core_p2 = 00, timeout_flags = 10, round proceeds, counters unchanged for the void round.
- Abort cap: core_game stays 00 for all rounds -> match_done after 19 rounds, match_result = 00, rounds_played = 19.
- Reset in APPLY: assert rst_n low -> all outputs 0 immediately, no match_done. match_req held during COLLECT -> no effect.
